// File: rtl/mpq_cmd_feeder_if.sv
// Host entry stream into the feeder and load/command strobes out to the queue stage.
// master = feeder side, slave = host/queue side.
interface mpq_cmd_feeder_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_kind;
    logic [7:0] in_data;
    logic [2:0] in_cmd;
    logic [7:0] in_index;
    logic [7:0] in_value;
    logic       q_rst;
    logic       data_valid;
    logic [7:0] data;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic [7:0] index;
    logic [7:0] value;
    logic       busy;
    logic       done;

    modport master (
        input  in_valid, in_kind, in_data, in_cmd, in_index, in_value, busy, done,
        output in_ready, q_rst, data_valid, data, cmd_valid, cmd, index, value
    );

    modport slave (
        output in_valid, in_kind, in_data, in_cmd, in_index, in_value, busy, done,
        input  in_ready, q_rst, data_valid, data, cmd_valid, cmd, index, value
    );
endinterface

// File: rtl/mpq_cmd_feeder.sv
// Buffers host data/command entries and replays each frame to the queue as a burst plus busy-paced commands.
// Outputs registered (first word 2 cycles after the triggering push); in_ready = !full.
module mpq_cmd_feeder #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    mpq_cmd_feeder_if.master       bus,
    output logic                   frame_done,
    output logic                   err_proto,
    output logic                   err_underrun,
    output logic [7:0]             cmd_count
);
    localparam int AW = $clog2(DEPTH);

    // data words ride in the index field
    typedef struct packed {
        logic       kind;
        logic [7:0] word;
        logic [7:0] value;
        logic [2:0] cmd;
    } entry_t;

    typedef enum logic [1:0] {IDLE, LOAD, CMD, DUMP} state_t;

    entry_t      mem [DEPTH];
    entry_t      head;
    entry_t      in_entry;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] cmd_entries;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;

    state_t      state, state_nxt;
    logic        q_rst_nxt, data_valid_nxt, cmd_valid_nxt, frame_done_nxt;
    logic        err_proto_nxt, err_underrun_nxt;
    logic [7:0]  data_nxt, index_nxt, value_nxt, cmd_count_nxt;
    logic [2:0]  cmd_nxt;

    assign empty        = (wr_ptr == rd_ptr);
    assign full         = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
    assign bus.in_ready = !full;
    assign push         = bus.in_valid && !full;
    assign head         = mem[rd_ptr[AW-1:0]];

    always_comb begin
        in_entry.kind  = bus.in_kind;
        in_entry.word  = bus.in_kind ? bus.in_index : bus.in_data;
        in_entry.value = bus.in_value;
        in_entry.cmd   = bus.in_cmd;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cmd_entries <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push && bus.in_kind, pop && head.kind})
                2'b10:   cmd_entries <= cmd_entries + 1'b1;
                2'b01:   cmd_entries <= cmd_entries - 1'b1;
                default: cmd_entries <= cmd_entries;
            endcase
        end
    end

    always_comb begin
        state_nxt        = state;
        pop              = 1'b0;
        q_rst_nxt        = bus.q_rst;
        data_valid_nxt   = 1'b0;
        data_nxt         = bus.data;
        cmd_valid_nxt    = 1'b0;
        cmd_nxt          = bus.cmd;
        index_nxt        = bus.index;
        value_nxt        = bus.value;
        frame_done_nxt   = 1'b0;
        err_proto_nxt    = err_proto;
        err_underrun_nxt = err_underrun;
        cmd_count_nxt    = cmd_count;
        case (state)
            IDLE: begin
                q_rst_nxt = 1'b1;
                if (!empty) begin
                    if (head.kind) begin
                        pop           = 1'b1;
                        err_proto_nxt = 1'b1;
                    end else if (cmd_entries != '0 || full) begin
                        state_nxt = LOAD;
                    end
                end
            end
            LOAD: begin
                if (!empty && !head.kind) begin
                    pop            = 1'b1;
                    q_rst_nxt      = 1'b0;
                    data_valid_nxt = 1'b1;
                    data_nxt       = head.word;
                end else begin
                    state_nxt = CMD;
                    if (empty) err_underrun_nxt = 1'b1;
                end
            end
            CMD: begin
                // blank cycle after each pulse gives the queue's registered busy time to rise
                if (!empty) begin
                    if (!head.kind) begin
                        pop           = 1'b1;
                        err_proto_nxt = 1'b1;
                    end else if (!bus.busy && !bus.cmd_valid) begin
                        pop           = 1'b1;
                        cmd_valid_nxt = 1'b1;
                        cmd_nxt       = head.cmd;
                        index_nxt     = head.word;
                        value_nxt     = head.value;
                        cmd_count_nxt = cmd_count + 8'd1;
                        if (head.cmd[2]) state_nxt = DUMP;
                    end
                end
            end
            DUMP: begin
                if (bus.done) begin
                    frame_done_nxt = 1'b1;
                    q_rst_nxt      = 1'b1;
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            bus.q_rst      <= 1'b1;
            bus.data_valid <= 1'b0;
            bus.data       <= '0;
            bus.cmd_valid  <= 1'b0;
            bus.cmd        <= '0;
            bus.index      <= '0;
            bus.value      <= '0;
            frame_done     <= 1'b0;
            err_proto      <= 1'b0;
            err_underrun   <= 1'b0;
            cmd_count      <= '0;
        end else begin
            state          <= state_nxt;
            bus.q_rst      <= q_rst_nxt;
            bus.data_valid <= data_valid_nxt;
            bus.data       <= data_nxt;
            bus.cmd_valid  <= cmd_valid_nxt;
            bus.cmd        <= cmd_nxt;
            bus.index      <= index_nxt;
            bus.value      <= value_nxt;
            frame_done     <= frame_done_nxt;
            err_proto      <= err_proto_nxt;
            err_underrun   <= err_underrun_nxt;
            cmd_count      <= cmd_count_nxt;
        end
    end
endmodule

// File: tb/tb_mpq_cmd_feeder.sv
// Bench for mpq_cmd_feeder: directed frames plus random frames scored against a frame-level model.
module tb_mpq_cmd_feeder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mpq_cmd_feeder_if bus();
    mpq_cmd_feeder_if bus4();
    logic       frame_done, err_proto, err_underrun;
    logic [7:0] cmd_count;
    logic       fd4, ep4, eu4;
    logic [7:0] cc4;

    mpq_cmd_feeder #(.DEPTH(16)) u_dut (
        .clk(clk), .rst(rst), .bus(bus.master), .frame_done(frame_done),
        .err_proto(err_proto), .err_underrun(err_underrun), .cmd_count(cmd_count)
    );
    mpq_cmd_feeder #(.DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .bus(bus4.master), .frame_done(fd4),
        .err_proto(ep4), .err_underrun(eu4), .cmd_count(cc4)
    );

    typedef struct packed {
        logic [2:0] c;
        logic [7:0] i;
        logic [7:0] v;
    } cmd_t;

    int   checks = 0;
    int   errors = 0;
    logic [7:0] exp_data[$];
    cmd_t exp_cmds[$];
    int   ph = 0;
    logic exp_err = 1'b0;
    int   exp_issued = 0;
    int   frames_exp = 0;
    int   fd_seen = 0;
    logic mon_en = 1'b0;
    logic rand_q = 1'b0;
    logic busy_force = 1'b0;
    logic done_force = 1'b1;
    logic exp_qrst = 1'b1;
    logic prev_cv = 1'b0, prev_dv = 1'b0, prev_busy = 1'b0;
    logic in_dump = 1'b0, dump_done_prev = 1'b0, burst_over = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame grammar: leading commands dropped, data up to the first command is the burst,
    // commands are issued in order, data among commands dropped, a write command ends the frame.
    function automatic void model_accept(input logic k, input logic [7:0] d, input cmd_t c);
        if (!k) begin
            if (ph == 2) exp_err = 1'b1;
            else begin
                exp_data.push_back(d);
                ph = 1;
            end
        end else begin
            if (ph == 0) exp_err = 1'b1;
            else begin
                exp_cmds.push_back(c);
                exp_issued++;
                if (c.c >= 3'd4) begin
                    ph = 0;
                    frames_exp++;
                end else ph = 2;
            end
        end
    endfunction

    task automatic push(input logic k, input logic [7:0] d, input logic [2:0] c,
                        input logic [7:0] i, input logic [7:0] v);
        logic acc = 1'b0;
        cmd_t ce;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_kind = k; bus.in_data = d;
        bus.in_cmd = c; bus.in_index = i; bus.in_value = v;
        for (int n = 0; n < 5000 && !acc; n++) begin
            acc = bus.in_ready;
            @(posedge clk);
            if (!acc) @(negedge clk);
        end
        #1 bus.in_valid = 1'b0;
        ce.c = c; ce.i = i; ce.v = v;
        if (acc) model_accept(k, d, ce);
        else chk("push_timeout", 32'(bus.in_ready), 1);
    endtask

    task automatic rpush(input logic k, input logic [7:0] d, input logic [2:0] c);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        push(k, d, c, 8'($urandom), 8'($urandom));
    endtask

    task automatic wait_drain(input int budget);
        for (int n = 0; n < budget && (fd_seen != frames_exp || exp_data.size() != 0
                                       || exp_cmds.size() != 0); n++)
            @(negedge clk);
        chk("drain_frames", fd_seen, frames_exp);
        chk("drain_cmds", exp_cmds.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rand_q) begin
                bus.busy = ($urandom_range(0, 3) == 0);
                bus.done = ($urandom_range(0, 2) == 0);
            end else begin
                bus.busy = busy_force;
                bus.done = done_force;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.data_valid) begin
                if (exp_data.size() == 0) chk("data_extra", 32'(bus.data_valid), 0);
                else chk("data", 32'(bus.data), 32'(exp_data.pop_front()));
                exp_qrst = 1'b0;
            end
            if (bus.cmd_valid) begin
                if (exp_cmds.size() == 0) chk("cmd_extra", 32'(bus.cmd_valid), 0);
                else chk("cmd", 32'({bus.cmd, bus.index, bus.value}), 32'(exp_cmds.pop_front()));
                if (bus.cmd >= 3'd4) in_dump = 1'b1;
            end
            chk("cmd_spacing", 32'(bus.cmd_valid & prev_cv), 0);
            chk("cmd_while_busy", 32'(bus.cmd_valid & prev_busy), 0);
            chk("cmd_after_burst", 32'(bus.cmd_valid & prev_dv), 0);
            chk("burst_gap", 32'(bus.data_valid & burst_over), 0);
            chk("frame_done", 32'(frame_done), 32'(dump_done_prev));
            if (frame_done) begin
                fd_seen++;
                exp_qrst = 1'b1;
                burst_over = 1'b0;
            end
            chk("q_rst", 32'(bus.q_rst), 32'(exp_qrst));
            if (prev_dv && !bus.data_valid) burst_over = 1'b1;
            dump_done_prev = in_dump & bus.done;
            if (dump_done_prev) in_dump = 1'b0;
            prev_cv = bus.cmd_valid;
            prev_dv = bus.data_valid;
            prev_busy = bus.busy;
        end
    end

    initial begin
        logic [7:0] w4[4];
        logic [7:0] got[$];
        int first_dv, cv, fd, nd, nc;
        bus.in_valid = 1'b0; bus.in_kind = 1'b0; bus.in_data = '0;
        bus.in_cmd = '0; bus.in_index = '0; bus.in_value = '0;
        bus4.in_valid = 1'b0; bus4.in_kind = 1'b0; bus4.in_data = '0;
        bus4.in_cmd = '0; bus4.in_index = '0; bus4.in_value = '0;
        bus4.busy = 1'b0; bus4.done = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("rst_q_rst", 32'(bus.q_rst), 1);
        chk("rst_data_valid", 32'(bus.data_valid), 0);
        chk("rst_cmd_valid", 32'(bus.cmd_valid), 0);
        chk("rst_data", 32'(bus.data), 0);
        chk("rst_cmd", 32'(bus.cmd), 0);
        chk("rst_index", 32'(bus.index), 0);
        chk("rst_value", 32'(bus.value), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_err_proto", 32'(err_proto), 0);
        chk("rst_err_underrun", 32'(err_underrun), 0);
        chk("rst_cmd_count", 32'(cmd_count), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        // basic frame
        push(0, 8'd5, 0, 0, 0); push(0, 8'd3, 0, 0, 0);
        push(0, 8'd8, 0, 0, 0); push(0, 8'd1, 0, 0, 0);
        push(1, 0, 3'd0, 8'h12, 8'h34);
        push(1, 0, 3'd4, 8'h56, 8'h78);
        wait_drain(300);
        chk("f1_cmd_count", 32'(cmd_count), 2);
        chk("f1_q_rst", 32'(bus.q_rst), 1);
        chk("f1_err_proto", 32'(err_proto), 0);

        // busy held high after the first of three commands
        push(0, 8'h11, 0, 0, 0); push(0, 8'h22, 0, 0, 0);
        push(1, 0, 3'd1, 8'h01, 8'h02);
        push(1, 0, 3'd2, 8'h03, 8'h04);
        push(1, 0, 3'd5, 8'h05, 8'h06);
        for (int n = 0; n < 200 && !bus.cmd_valid; n++) @(negedge clk);
        chk("busy_first_cmd", 32'(bus.cmd_valid), 1);
        busy_force = 1'b1;
        repeat (10) @(negedge clk);
        busy_force = 1'b0;
        @(negedge clk);
        chk("busy_release_wait", 32'(bus.cmd_valid), 0);
        @(negedge clk);
        chk("busy_release_issue", 32'(bus.cmd_valid), 1);
        wait_drain(300);

        // stray leading command
        push(1, 0, 3'd1, 8'h99, 8'h98);
        push(0, 8'd7, 0, 0, 0);
        push(1, 0, 3'd4, 8'hAB, 8'hCD);
        wait_drain(300);
        chk("stray_err_proto", 32'(err_proto), 1);

        // random frames with random busy/done
        rand_q = 1'b1;
        for (int f = 0; f < 30; f++) begin
            if ($urandom_range(0, 3) == 0) rpush(1, 0, 3'($urandom));
            nd = $urandom_range(1, 6);
            for (int j = 0; j < nd; j++) rpush(0, 8'($urandom), 0);
            nc = $urandom_range(0, 2);
            for (int j = 0; j < nc; j++) begin
                rpush(1, 0, 3'($urandom_range(0, 3)));
                if ($urandom_range(0, 3) == 0) rpush(0, 8'($urandom), 0);
            end
            rpush(1, 0, 3'($urandom_range(4, 7)));
        end
        wait_drain(20000);
        rand_q = 1'b0;
        repeat (2) @(negedge clk);
        chk("rand_err_proto", 32'(err_proto), 32'(exp_err));
        chk("rand_cmd_count", 32'(cmd_count), 32'(exp_issued % 256));
        chk("rand_err_underrun", 32'(err_underrun), 0);

        // DEPTH=4: fill, burst on full, underrun
        for (int k = 0; k < 4; k++) begin
            w4[k] = 8'($urandom);
            @(negedge clk);
            chk("d4_ready", 32'(bus4.in_ready), 1);
            bus4.in_valid = 1'b1; bus4.in_kind = 1'b0; bus4.in_data = w4[k];
            @(posedge clk);
            #1 bus4.in_valid = 1'b0;
        end
        @(negedge clk);
        chk("d4_full_ready", 32'(bus4.in_ready), 0);
        first_dv = -1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (bus4.data_valid) begin
                if (first_dv < 0) first_dv = n;
                got.push_back(bus4.data);
            end
        end
        chk("d4_burst_start", first_dv, 1);
        chk("d4_burst_len", got.size(), 4);
        for (int k = 0; k < 4; k++)
            if (k < got.size()) chk("d4_word", 32'(got[k]), 32'(w4[k]));
        chk("d4_underrun", 32'(eu4), 1);
        chk("d4_q_rst", 32'(bus4.q_rst), 0);
        @(negedge clk);
        bus4.in_valid = 1'b1; bus4.in_kind = 1'b1; bus4.in_cmd = 3'd5;
        bus4.in_index = 8'h44; bus4.in_value = 8'h55;
        chk("d4_cmd_ready", 32'(bus4.in_ready), 1);
        @(posedge clk);
        #1 bus4.in_valid = 1'b0;
        cv = 0; fd = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus4.cmd_valid) begin
                cv++;
                chk("d4_cmd", 32'({bus4.cmd, bus4.index, bus4.value}), 32'({3'd5, 8'h44, 8'h55}));
            end
            if (fd4) fd++;
        end
        chk("d4_cmd_pulses", cv, 1);
        chk("d4_frame_done", fd, 1);
        chk("d4_cmd_count", 32'(cc4), 1);

        // reset in the middle of a 6-word burst
        mon_en = 1'b0;
        for (int j = 0; j < 6; j++) push(0, 8'($urandom), 0, 0, 0);
        push(1, 0, 3'd4, 8'h10, 8'h20);
        for (int n = 0; n < 100 && !bus.data_valid; n++) @(negedge clk);
        chk("mid_burst_start", 32'(bus.data_valid), 1);
        repeat (2) @(negedge clk);
        chk("mid_burst_active", 32'(bus.data_valid), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_data_valid", 32'(bus.data_valid), 0);
        chk("mid_rst_q_rst", 32'(bus.q_rst), 1);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 1);
        chk("mid_rst_err_proto", 32'(err_proto), 0);
        chk("mid_rst_err_underrun", 32'(err_underrun), 0);
        chk("mid_rst_cmd_count", 32'(cmd_count), 0);
        chk("mid_rst_d4_underrun", 32'(eu4), 0);
        @(negedge clk);
        rst = 1'b0;
        exp_data.delete(); exp_cmds.delete();
        ph = 0; exp_err = 1'b0; exp_issued = 0; frames_exp = 0; fd_seen = 0;
        exp_qrst = 1'b1; prev_cv = 1'b0; prev_dv = 1'b0; prev_busy = 1'b0;
        in_dump = 1'b0; dump_done_prev = 1'b0; burst_over = 1'b0;
        mon_en = 1'b1;
        push(0, 8'h5A, 0, 0, 0); push(0, 8'hC3, 0, 0, 0); push(0, 8'h0F, 0, 0, 0);
        push(1, 0, 3'd3, 8'h31, 8'h32);
        push(1, 0, 3'd6, 8'h61, 8'h62);
        wait_drain(300);
        chk("replay_cmd_count", 32'(cmd_count), 2);
        chk("replay_err_proto", 32'(err_proto), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
